// File: rtl/p2s_pkg.sv
// Shared serial/parallel package: one-hot controller states and default word width.
// Used by s2p_receiver (optional error flags guarded by S2P_ERR_EN) and the transmit side.
package p2s_pkg;

    localparam int unsigned DefaultWidth = 8;

    // One-hot state codes shared with the transmit controller
    localparam logic [2:0] IDLE  = 3'b001;
    localparam logic [2:0] SHIFT = 3'b010;
    localparam logic [2:0] HOLD  = 3'b100;

    typedef enum logic [2:0] {
        StIdle  = IDLE,
        StShift = SHIFT,
        StHold  = HOLD
    } state_e;

endpackage

// File: rtl/s2p_shreg.sv
// Serial-in shift register plus parallel output capture for s2p_receiver.
// Bits enter at the LSB, so the first bit of a word ends up in dout[W-1].
module s2p_shreg
    import p2s_pkg::*;
#(
    parameter int unsigned W = DefaultWidth
) (
    input  logic         ck,
    input  logic         reset,
    input  logic         shift_en,
    input  logic         load_en,
    input  logic         din,
    output logic [W-1:0] dout
);

    logic [W-1:0] shreg_q, shreg_d;
    logic [W-1:0] dout_q, dout_d;
    logic [W-1:0] word;

    // Completed word includes the bit being sampled on this edge
    assign word = {shreg_q[W-2:0], din};

    // Next-state for shift register and captured output word
    always_comb begin
        shreg_d = shreg_q;
        dout_d  = dout_q;
        if (shift_en) begin
            shreg_d = word;
        end
        if (load_en) begin
            dout_d = word;
        end
    end

    // Register update with asynchronous active-low reset
    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            shreg_q <= '0;
            dout_q  <= '0;
        end else begin
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/s2p_receiver.sv
// Serial-to-parallel receiver: MSB-first bit stream in, W-bit word out with OK/ack handshake.
// Define S2P_ERR_EN to build the framing-error pulse and sticky overrun flag;
// otherwise frm_err and ovr are tied low and the data path is unchanged.
module s2p_receiver
    import p2s_pkg::*;
#(
    parameter int unsigned W = DefaultWidth
) (
    input  logic         ck,
    input  logic         reset,
    input  logic         VI,
    input  logic         din,
    input  logic         ack,
    output logic [W-1:0] dout,
    output logic         OK,
    output logic         busy,
    output logic         frm_err,
    output logic         ovr
);

    localparam int unsigned     CntW    = $clog2(W);
    localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);
    localparam logic [CntW-1:0] OneCnt  = CntW'(1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            shift_en;
    logic            load_en;

    s2p_shreg #(
        .W (W)
    ) u_shreg (
        .ck       (ck),
        .reset    (reset),
        .shift_en (shift_en),
        .load_en  (load_en),
        .din      (din),
        .dout     (dout)
    );

    // Next-state, bit counter and shift-register controls
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_en = 1'b0;
        load_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (VI) begin
                    shift_en = 1'b1;
                    cnt_d    = OneCnt;
                    state_d  = StShift;
                end
            end
            StShift: begin
                if (!VI) begin
                    // Abort: partial word is dropped, dout untouched
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (cnt_q == LastCnt) begin
                    shift_en = 1'b1;
                    load_en  = 1'b1;
                    cnt_d    = '0;
                    state_d  = StHold;
                end else begin
                    shift_en = 1'b1;
                    cnt_d    = cnt_q + OneCnt;
                end
            end
            StHold: begin
                if (ack) begin
                    if (VI) begin
                        // Accept and start the next word on the same edge
                        shift_en = 1'b1;
                        cnt_d    = OneCnt;
                        state_d  = StShift;
                    end else begin
                        state_d = StIdle;
                    end
                end
                // ack=0 with VI=1: bit is dropped, word held
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign OK   = (state_q == StHold);
    assign busy = (state_q == StShift);

`ifdef S2P_ERR_EN
    logic frm_err_q;
    logic ovr_q;

    // Framing-error pulse and sticky overrun flag
    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            frm_err_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            frm_err_q <= (state_q == StShift) && !VI;
            ovr_q     <= ovr_q | ((state_q == StHold) && !ack && VI);
        end
    end

    assign frm_err = frm_err_q;
    assign ovr     = ovr_q;
`else
    assign frm_err = 1'b0;
    assign ovr     = 1'b0;
`endif

endmodule

// File: tb/tb_s2p_receiver.sv
// Self-checking bench for s2p_receiver (W=8). Expected words go into a scoreboard queue;
// a monitor pops and compares each word when it is accepted (OK && ack).
// Flag expectations follow S2P_ERR_EN.
module tb_s2p_receiver;

    localparam int unsigned W = 8;
`ifdef S2P_ERR_EN
    localparam logic ErrEn = 1'b1;
`else
    localparam logic ErrEn = 1'b0;
`endif

    logic         ck;
    logic         reset;
    logic         VI;
    logic         din;
    logic         ack;
    logic [W-1:0] dout;
    logic         OK;
    logic         busy;
    logic         frm_err;
    logic         ovr;

    int           n_cmp;
    int           n_err;
    logic [W-1:0] sb_q[$];
    logic         frm_any;

    s2p_receiver #(
        .W (W)
    ) dut (
        .ck      (ck),
        .reset   (reset),
        .VI      (VI),
        .din     (din),
        .ack     (ack),
        .dout    (dout),
        .OK      (OK),
        .busy    (busy),
        .frm_err (frm_err),
        .ovr     (ovr)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, let the edge happen, settle 1 time unit after it
    task automatic step(input logic vi, input logic d, input logic a);
        VI  = vi;
        din = d;
        ack = a;
        @(posedge ck);
        #1;
        frm_any = frm_any | (frm_err === 1'b1);
    endtask

    // Send one word MSB first; ack_first drives ack on the first bit (streaming from HOLD)
    task automatic send_word(input logic [W-1:0] w, input logic ack_first);
        for (int i = W - 1; i >= 0; i--) begin
            step(1'b1, w[i], (i == W - 1) ? ack_first : 1'b0);
        end
    endtask

    // Monitor: compare dout against scoreboard whenever a word is accepted
    initial begin
        forever begin
            @(negedge ck);
            if (reset === 1'b1 && OK === 1'b1 && ack === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_word", {24'd0, dout}, 32'hFFFF_FFFF);
                end else begin
                    check("sb_word", {24'd0, dout}, {24'd0, sb_q.pop_front()});
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        frm_any = 1'b0;
        reset   = 1'b0;
        VI      = 1'b0;
        din     = 1'b0;
        ack     = 1'b0;

        // Reset state, before any clock edge
        #2;
        check("rst_dout", {24'd0, dout}, 32'h0);
        check("rst_ok", {31'd0, OK}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_frm", {31'd0, frm_err}, 32'h0);
        check("rst_ovr", {31'd0, ovr}, 32'h0);
        @(negedge ck);
        @(negedge ck);
        reset = 1'b1;

        // Basic word 8'hB2
        sb_q.push_back(8'hB2);
        send_word(8'hB2, 1'b0);
        check("basic_ok", {31'd0, OK}, 32'h1);
        check("basic_busy", {31'd0, busy}, 32'h0);
        check("basic_dout", {24'd0, dout}, 32'hB2);
        step(1'b0, 1'b0, 1'b1);
        check("basic_idle_ok", {31'd0, OK}, 32'h0);

        // Abort after 3 bits
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("abort_busy", {31'd0, busy}, 32'h1);
        step(1'b0, 1'b0, 1'b0);
        check("abort_frm", {31'd0, frm_err}, {31'd0, ErrEn});
        check("abort_busy_low", {31'd0, busy}, 32'h0);
        check("abort_ok_low", {31'd0, OK}, 32'h0);
        check("abort_dout", {24'd0, dout}, 32'hB2);
        step(1'b0, 1'b0, 1'b0);
        check("abort_frm_pulse", {31'd0, frm_err}, 32'h0);
        sb_q.push_back(8'h5A);
        send_word(8'h5A, 1'b0);
        check("abort_next_dout", {24'd0, dout}, 32'h5A);
        step(1'b0, 1'b0, 1'b1);

        // Overrun: A5 held, 8 more bits without ack
        sb_q.push_back(8'hA5);
        send_word(8'hA5, 1'b0);
        check("ovr_pre", {31'd0, ovr}, 32'h0);
        step(1'b1, 1'b0, 1'b0);
        check("ovr_set", {31'd0, ovr}, {31'd0, ErrEn});
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, 1'b0);
        end
        check("ovr_ok_held", {31'd0, OK}, 32'h1);
        check("ovr_dout_held", {24'd0, dout}, 32'hA5);
        step(1'b0, 1'b0, 1'b1);
        check("ovr_sticky", {31'd0, ovr}, {31'd0, ErrEn});
        check("ovr_idle", {31'd0, OK}, 32'h0);

        // Streaming 3C then C3, ack in the HOLD cycle that carries the next first bit
        frm_any = 1'b0;
        sb_q.push_back(8'h3C);
        sb_q.push_back(8'hC3);
        send_word(8'h3C, 1'b0);
        send_word(8'hC3, 1'b1);
        check("stream_dout", {24'd0, dout}, 32'hC3);
        check("stream_ok", {31'd0, OK}, 32'h1);
        step(1'b0, 1'b0, 1'b1);
        check("stream_no_frm", {31'd0, frm_any}, 32'h0);

        // Asynchronous reset after 4 bits
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0);
        end
        check("rstmid_busy", {31'd0, busy}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("rstmid_dout", {24'd0, dout}, 32'h0);
        check("rstmid_busy0", {31'd0, busy}, 32'h0);
        check("rstmid_ok", {31'd0, OK}, 32'h0);
        check("rstmid_frm", {31'd0, frm_err}, 32'h0);
        check("rstmid_ovr", {31'd0, ovr}, 32'h0);
        VI = 1'b0;
        @(posedge ck);
        #1;
        check("rstmid_frm_edge", {31'd0, frm_err}, 32'h0);
        @(negedge ck);
        reset = 1'b1;
        sb_q.push_back(8'hFF);
        send_word(8'hFF, 1'b0);
        check("rstmid_next_dout", {24'd0, dout}, 32'hFF);
        check("rstmid_next_ovr", {31'd0, ovr}, 32'h0);
        step(1'b0, 1'b0, 1'b1);

        step(1'b0, 1'b0, 1'b0);
        check("sb_drained", sb_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
